umi_isolate_drain: RTL and testbench
====================================

Name: umi_isolate_drain

Overview:
- Multi-channel, packet-aware UMI isolation gate. Next generation of the combinational umi_isolate.
- On request, it stops new packets from starting on every channel and lets each in-flight packet finish (EOM beat).
- It then clamps all channels and acknowledges. A timeout forces isolation if a packet never completes.
- Sits at a power-domain or chiplet boundary. A bidirectional link uses two channels, one per direction.

Parameters:
- CH, 2, number of independent one-directional UMI channels
- CW, 32, command width
- AW, 64, address width
- DW, 256, data width
- EOMBIT, 22, bit index of EOM within cmd
- TIMEOUT, 1024, drain cycles before forced isolation; 0 disables timeout
- ISO, 1, 1 = isolation logic present; 0 = pure passthrough with ack = registered req and err = 0

Ports:
- clk  in  1  clock
- nreset  in  1  async active-low reset
- isolate_req  in  1  level request to isolate
- isolate_ack  out  1  all channels clamped
- isolate_err  out  1  sticky: last isolation was forced by timeout
- umi_in_valid  in  CH  upstream valid per channel
- umi_in_cmd  in  CH*CW  upstream cmd, channel c at [c*CW +: CW]
- umi_in_dstaddr  in  CH*AW  upstream dstaddr
- umi_in_srcaddr  in  CH*AW  upstream srcaddr
- umi_in_data  in  CH*DW  upstream data
- umi_in_ready  out  CH  ready to upstream
- umi_out_valid  out  CH  downstream valid
- umi_out_cmd  out  CH*CW  downstream cmd
- umi_out_dstaddr  out  CH*AW  downstream dstaddr
- umi_out_srcaddr  out  CH*AW  downstream srcaddr
- umi_out_data  out  CH*DW  downstream data
- umi_out_ready  in  CH  ready from downstream

Behaviour:
- One clock; reset is asynchronous and active-low (clk, nreset).
- Reset values: state = OPEN, in_pkt = 0, counter = 0, isolate_ack = 0, isolate_err = 0.
- Per-channel in_pkt flag:
  - A beat is accepted when umi_in_valid & umi_in_ready.
  - Set on an accepted beat with cmd[EOMBIT] = 0; cleared on an accepted beat with cmd[EOMBIT] = 1.
  - A single-beat packet (EOM = 1) never sets the flag.
- Channel c is blocked when (state == DRAIN & ~in_pkt[c]) | state == ISOLATED.
- Blocked channel: umi_out_valid = 0, umi_out_cmd/dstaddr/srcaddr/data = 0, umi_in_ready = 0.
- Unblocked channel: pure combinational passthrough. umi_in_ready = umi_out_ready; zero added latency.
- State machine:
  - OPEN: counter = 0. If isolate_req = 1, go to DRAIN and clear isolate_err.
  - DRAIN: counter increments every cycle.
    - If isolate_req = 0: go to OPEN (abort; ack never asserted).
    - Else if all in_pkt = 0 next cycle (no channel in a packet after this cycle's beats): go to ISOLATED.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1: go to ISOLATED, set isolate_err, clear all in_pkt (packets truncated).
  - ISOLATED: isolate_ack = 1. If isolate_req = 0, go to OPEN.
- isolate_ack is registered: 1 exactly while state == ISOLATED, so it rises the cycle after the transition condition.
- Minimum latency req→ack is 2 cycles when idle: one cycle in DRAIN, ack high on the next.
- Simultaneous events in DRAIN:
  - EOM acceptance on the last busy channel goes to ISOLATED the next cycle; the EOM beat itself passes.
  - If timeout and completion coincide, completion wins and isolate_err stays 0.
  - isolate_req dropping has priority over both.
- isolate_err holds through ISOLATED and OPEN until the next OPEN→DRAIN transition.
- Mid-packet upstream stall during DRAIN is legal; the channel stays unblocked until its EOM beat.
- Reset mid-operation: immediate return to reset values; in_pkt is lost.

Test Plan:
- CH=2, idle, req 0→1 at cycle 10 → DRAIN at 11, ack = 1 at 12, all out_valid = 0 and in_ready = 0 from cycle 11; req→0 at 20 → OPEN at 21, passthrough resumes.
- Channel 0 mid 4-beat packet (2 beats sent), req asserted → channel 1 blocked immediately; channel 0 passes remaining 2 beats (EOM on 4th); ack the cycle after the EOM beat is accepted.
- TIMEOUT=16, channel 0 stuck mid-packet with out_ready = 0 → ack and isolate_err = 1 after 16 DRAIN cycles; a new packet after release starts with in_pkt clear.
- req pulsed for 1 cycle while channel busy → DRAIN then OPEN, ack stays 0, no beats lost or duplicated.
- EOM beat accepted in the same cycle as counter = TIMEOUT-1 → ISOLATED with isolate_err = 0.
- Random traffic on both channels with random req toggling and reset asserted mid-DRAIN → scoreboard: downstream sees only whole packets except after a flagged timeout; all outputs return to 0 on reset.

Source files
------------

// File: rtl/umi_isolate_drain.sv
// Packet-aware UMI isolation gate: on request, blocks new packets, lets in-flight
// packets reach EOM (or a timeout), then clamps every channel and acknowledges.

module umi_isolate_drain_lane #(
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 256,
  parameter int EOMBIT = 22
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          blocked,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [CW-1:0] in_cmd,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_cmd,
  output logic [AW-1:0] out_dstaddr,
  output logic [AW-1:0] out_srcaddr,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          in_pkt_nxt
);
  logic in_pkt;
  logic accept;

  assign in_ready    = ~blocked & out_ready;
  assign out_valid   = ~blocked & in_valid;
  assign out_cmd     = blocked ? '0 : in_cmd;
  assign out_dstaddr = blocked ? '0 : in_dstaddr;
  assign out_srcaddr = blocked ? '0 : in_srcaddr;
  assign out_data    = blocked ? '0 : in_data;

  assign accept     = in_valid & in_ready;
  assign in_pkt_nxt = accept ? ~in_cmd[EOMBIT] : in_pkt;

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) in_pkt <= 1'b0;
    else         in_pkt <= clr ? 1'b0 : in_pkt_nxt;
endmodule

module umi_isolate_drain #(
  parameter int CH      = 2,
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int EOMBIT  = 22,
  parameter int TIMEOUT = 1024,
  parameter int ISO     = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             isolate_req,
  output logic             isolate_ack,
  output logic             isolate_err,
  input  logic [CH-1:0]    umi_in_valid,
  input  logic [CH*CW-1:0] umi_in_cmd,
  input  logic [CH*AW-1:0] umi_in_dstaddr,
  input  logic [CH*AW-1:0] umi_in_srcaddr,
  input  logic [CH*DW-1:0] umi_in_data,
  output logic [CH-1:0]    umi_in_ready,
  output logic [CH-1:0]    umi_out_valid,
  output logic [CH*CW-1:0] umi_out_cmd,
  output logic [CH*AW-1:0] umi_out_dstaddr,
  output logic [CH*AW-1:0] umi_out_srcaddr,
  output logic [CH*DW-1:0] umi_out_data,
  input  logic [CH-1:0]    umi_out_ready
);
  if (ISO != 0) begin : g_iso
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] TLAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {OPEN, DRAIN, ISOLATED} state_t;
    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [CH-1:0]   blocked;
    logic [CH-1:0]   in_pkt_nxt;
    logic            tmo_hit;
    logic            clr;

    assign tmo_hit = (TIMEOUT != 0) && (cnt == TLAST);
    // Completion beats a coincident timeout, so truncation only fires when a channel stays busy.
    assign clr     = (state == DRAIN) & isolate_req & (|in_pkt_nxt) & tmo_hit;

    for (genvar c = 0; c < CH; c++) begin : g_lane
      assign blocked[c] = (state == ISOLATED) | ((state == DRAIN) & ~in_pkt_nxt_q(c));
      umi_isolate_drain_lane #(.CW(CW), .AW(AW), .DW(DW), .EOMBIT(EOMBIT)) u_lane (
        .clk         (clk),
        .nreset      (nreset),
        .blocked     (blocked[c]),
        .clr         (clr),
        .in_valid    (umi_in_valid[c]),
        .in_cmd      (umi_in_cmd[c*CW +: CW]),
        .in_dstaddr  (umi_in_dstaddr[c*AW +: AW]),
        .in_srcaddr  (umi_in_srcaddr[c*AW +: AW]),
        .in_data     (umi_in_data[c*DW +: DW]),
        .in_ready    (umi_in_ready[c]),
        .out_valid   (umi_out_valid[c]),
        .out_cmd     (umi_out_cmd[c*CW +: CW]),
        .out_dstaddr (umi_out_dstaddr[c*AW +: AW]),
        .out_srcaddr (umi_out_srcaddr[c*AW +: AW]),
        .out_data    (umi_out_data[c*DW +: DW]),
        .out_ready   (umi_out_ready[c]),
        .in_pkt_nxt  (in_pkt_nxt[c])
      );
    end

    // Blocking must look at the registered packet flag, not the next-state value,
    // otherwise the gate would feed back on itself.
    logic [CH-1:0] in_pkt_q;
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) in_pkt_q <= '0;
      else         in_pkt_q <= clr ? '0 : in_pkt_nxt;

    function automatic logic in_pkt_nxt_q(input int idx);
      return in_pkt_q[idx];
    endfunction

    always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
        state       <= OPEN;
        cnt         <= '0;
        isolate_ack <= 1'b0;
        isolate_err <= 1'b0;
      end else begin
        case (state)
          OPEN: begin
            cnt <= '0;
            if (isolate_req) begin
              state       <= DRAIN;
              isolate_err <= 1'b0;
            end
          end
          DRAIN: begin
            cnt <= cnt + 1'b1;
            if (!isolate_req) begin
              state <= OPEN;
            end else if (~|in_pkt_nxt) begin
              state       <= ISOLATED;
              isolate_ack <= 1'b1;
            end else if (tmo_hit) begin
              state       <= ISOLATED;
              isolate_ack <= 1'b1;
              isolate_err <= 1'b1;
            end
          end
          ISOLATED: begin
            if (!isolate_req) begin
              state       <= OPEN;
              isolate_ack <= 1'b0;
            end
          end
          default: begin
            state       <= OPEN;
            isolate_ack <= 1'b0;
          end
        endcase
      end
  end else begin : g_pass
    assign umi_out_valid   = umi_in_valid;
    assign umi_out_cmd     = umi_in_cmd;
    assign umi_out_dstaddr = umi_in_dstaddr;
    assign umi_out_srcaddr = umi_in_srcaddr;
    assign umi_out_data    = umi_in_data;
    assign umi_in_ready    = umi_out_ready;
    assign isolate_err     = 1'b0;

    always_ff @(posedge clk or negedge nreset)
      if (!nreset) isolate_ack <= 1'b0;
      else         isolate_ack <= isolate_req;
  end
endmodule

// File: tb/tb_umi_isolate_drain.sv
// Bench for umi_isolate_drain: directed vector table, hand-written drain/timeout
// sequences, then random traffic against a cycle-level behavioural model.

module tb_umi_isolate_drain;
  localparam int CH = 2, CW = 32, AW = 64, DW = 64, EOMBIT = 22, TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             nreset;
  logic             isolate_req;
  logic             isolate_ack, isolate_err;
  logic [CH-1:0]    umi_in_valid, umi_in_ready, umi_out_valid, umi_out_ready;
  logic [CH*CW-1:0] umi_in_cmd, umi_out_cmd;
  logic [CH*AW-1:0] umi_in_dstaddr, umi_in_srcaddr, umi_out_dstaddr, umi_out_srcaddr;
  logic [CH*DW-1:0] umi_in_data, umi_out_data;

  umi_isolate_drain #(.CH(CH), .CW(CW), .AW(AW), .DW(DW), .EOMBIT(EOMBIT),
                      .TIMEOUT(TIMEOUT), .ISO(1)) dut (
    .clk(clk), .nreset(nreset), .isolate_req(isolate_req),
    .isolate_ack(isolate_ack), .isolate_err(isolate_err),
    .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
    .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
    .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
    .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
    .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
    .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the gate is doing, how long it has drained, who is mid-packet.
  int       mode;          // 0 open, 1 draining, 2 isolated
  int       drained;
  bit [CH-1:0] busy;
  bit       merr;
  bit       ev_done, ev_tmo;
  bit [CH-1:0] sb_open;    // downstream view: channel has seen a packet start without its EOM

  // Values sampled mid-cycle, for the directed checks.
  logic          s_ack, s_err;
  logic [CH-1:0] s_ov, s_ir;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; drained = 0; busy = '0; merr = 0; sb_open = '0;
  endtask

  task automatic cycle(input bit req, input logic [CH-1:0] v, input logic [CH-1:0] e,
                       input logic [CH-1:0] r);
    logic [CW-1:0]    cmd;
    logic [CH-1:0]    blk, exp_ov, exp_ir, acc, nb;
    logic [CH*CW-1:0] exp_cmd;
    logic [CH*AW-1:0] exp_dst, exp_src;
    logic [CH*DW-1:0] exp_data;
    isolate_req   = req;
    umi_in_valid  = v;
    umi_out_ready = r;
    for (int c = 0; c < CH; c++) begin
      cmd = $urandom;
      cmd[EOMBIT] = e[c];
      umi_in_cmd[c*CW +: CW]     = cmd;
      umi_in_dstaddr[c*AW +: AW] = {$urandom, $urandom};
      umi_in_srcaddr[c*AW +: AW] = {$urandom, $urandom};
      umi_in_data[c*DW +: DW]    = {$urandom, $urandom};
    end
    #3;
    for (int c = 0; c < CH; c++) begin
      blk[c]    = (mode == 2) || (mode == 1 && !busy[c]);
      exp_ov[c] = !blk[c] && v[c];
      exp_ir[c] = !blk[c] && r[c];
      exp_cmd[c*CW +: CW]  = blk[c] ? '0 : umi_in_cmd[c*CW +: CW];
      exp_dst[c*AW +: AW]  = blk[c] ? '0 : umi_in_dstaddr[c*AW +: AW];
      exp_src[c*AW +: AW]  = blk[c] ? '0 : umi_in_srcaddr[c*AW +: AW];
      exp_data[c*DW +: DW] = blk[c] ? '0 : umi_in_data[c*DW +: DW];
    end
    s_ack = isolate_ack; s_err = isolate_err; s_ov = umi_out_valid; s_ir = umi_in_ready;
    chk("ack", isolate_ack, mode == 2);
    chk("err", isolate_err, merr);
    chk("out_valid", umi_out_valid, exp_ov);
    chk("in_ready", umi_in_ready, exp_ir);
    chk("out_cmd", umi_out_cmd, exp_cmd);
    chk("out_dstaddr", umi_out_dstaddr, exp_dst);
    chk("out_srcaddr", umi_out_srcaddr, exp_src);
    chk("out_data", umi_out_data, exp_data);
    for (int c = 0; c < CH; c++)
      if (umi_out_valid[c] && umi_out_ready[c])
        sb_open[c] = !umi_out_cmd[c*CW + EOMBIT];
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      acc[c] = v[c] && exp_ir[c];
      nb[c]  = acc[c] ? !e[c] : busy[c];
    end
    ev_done = 0; ev_tmo = 0;
    case (mode)
      0: if (req) begin mode = 1; drained = 0; merr = 0; end
      1: begin
        drained++;
        if (!req) mode = 0;
        else if (nb == '0) begin mode = 2; ev_done = 1; end
        else if (drained == TIMEOUT) begin mode = 2; merr = 1; nb = '0; ev_tmo = 1; end
      end
      default: if (!req) mode = 0;
    endcase
    busy = nb;
    if (ev_done) chk("whole_pkt", sb_open, '0);
    if (ev_tmo) sb_open = '0;
    #1;
  endtask

  task automatic do_reset();
    isolate_req = 0; umi_in_valid = '0; umi_out_ready = '0;
    umi_in_cmd = '0; umi_in_dstaddr = '0; umi_in_srcaddr = '0; umi_in_data = '0;
    nreset = 0;
    #2;
    chk("rst_ack", isolate_ack, 1'b0);
    chk("rst_err", isolate_err, 1'b0);
    chk("rst_out_valid", umi_out_valid, '0);
    chk("rst_in_ready", umi_in_ready, '0);
    chk("rst_out_data", umi_out_data, '0);
    @(posedge clk); #1;
    nreset = 1;
    model_reset();
  endtask

  typedef struct {
    bit            req;
    logic [CH-1:0] v, e, r;
    bit            ack, err;
    logic [CH-1:0] ov, ir;
  } vec_t;
  vec_t tbl[13];

  initial begin
    // Directed walk: mid-packet drain on ch0, idle drain, release and resume.
    tbl[0]  = '{0, 2'b11, 2'b11, 2'b11, 0, 0, 2'b11, 2'b11};
    tbl[1]  = '{0, 2'b01, 2'b00, 2'b11, 0, 0, 2'b01, 2'b11};
    tbl[2]  = '{1, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 2'b11};
    tbl[3]  = '{1, 2'b11, 2'b00, 2'b11, 0, 0, 2'b01, 2'b01};
    tbl[4]  = '{1, 2'b11, 2'b11, 2'b11, 0, 0, 2'b01, 2'b01};
    tbl[5]  = '{1, 2'b11, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00};
    tbl[6]  = '{0, 2'b11, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00};
    tbl[7]  = '{0, 2'b11, 2'b11, 2'b11, 0, 0, 2'b11, 2'b11};
    tbl[8]  = '{1, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 2'b11};
    tbl[9]  = '{1, 2'b11, 2'b11, 2'b11, 0, 0, 2'b00, 2'b00};
    tbl[10] = '{1, 2'b11, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00};
    tbl[11] = '{0, 2'b00, 2'b00, 2'b11, 1, 0, 2'b00, 2'b00};
    tbl[12] = '{0, 2'b10, 2'b10, 2'b10, 0, 0, 2'b10, 2'b10};

    nreset = 1;
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].req, tbl[i].v, tbl[i].e, tbl[i].r);
      chk($sformatf("tbl%0d_ack", i), s_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
      chk($sformatf("tbl%0d_ov", i), s_ov, tbl[i].ov);
      chk($sformatf("tbl%0d_ir", i), s_ir, tbl[i].ir);
    end

    // Stuck packet on ch0: forced isolation after TIMEOUT drain cycles.
    do_reset();
    cycle(0, 2'b01, 2'b00, 2'b11);
    cycle(1, 2'b00, 2'b00, 2'b11);
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle(1, 2'b01, 2'b00, 2'b00);
      chk("tmo_wait_ack", s_ack, 1'b0);
    end
    cycle(1, 2'b00, 2'b00, 2'b11);
    chk("tmo_ack", s_ack, 1'b1);
    chk("tmo_err", s_err, 1'b1);
    cycle(0, 2'b00, 2'b00, 2'b11);
    cycle(0, 2'b01, 2'b01, 2'b11);
    chk("tmo_err_hold", s_err, 1'b1);
    chk("tmo_reopen_ov", s_ov, 2'b01);
    cycle(1, 2'b00, 2'b00, 2'b11);
    cycle(1, 2'b00, 2'b00, 2'b11);
    chk("redrain_err_clr", s_err, 1'b0);
    cycle(1, 2'b00, 2'b00, 2'b11);
    chk("redrain_ack", s_ack, 1'b1);

    // EOM on the very cycle the timeout would fire: completion wins.
    do_reset();
    cycle(0, 2'b01, 2'b00, 2'b11);
    cycle(1, 2'b00, 2'b00, 2'b11);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1, 2'b01, 2'b00, 2'b00);
    cycle(1, 2'b01, 2'b01, 2'b01);
    chk("coinc_eom_pass", s_ov, 2'b01);
    cycle(1, 2'b00, 2'b00, 2'b11);
    chk("coinc_ack", s_ack, 1'b1);
    chk("coinc_err", s_err, 1'b0);

    // One-cycle request pulse while busy: drain aborts, no ack.
    do_reset();
    cycle(0, 2'b01, 2'b00, 2'b11);
    cycle(1, 2'b00, 2'b00, 2'b11);
    cycle(0, 2'b11, 2'b00, 2'b11);
    chk("pulse_ov", s_ov, 2'b01);
    cycle(0, 2'b11, 2'b01, 2'b11);
    chk("pulse_ack", s_ack, 1'b0);
    chk("pulse_reopen", s_ov, 2'b11);

    // Random traffic, request toggling and resets landing mid-drain.
    do_reset();
    begin
      bit req = 0;
      for (int i = 0; i < 4000; i++) begin
        logic [CH-1:0] v, e, r;
        if ($urandom_range(0, 9) == 0) req = !req;
        for (int c = 0; c < CH; c++) begin
          v[c] = $urandom_range(0, 2) != 0;
          e[c] = $urandom_range(0, 2) == 0;
          r[c] = ((i / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        end
        if (mode == 1 && $urandom_range(0, 24) == 0) begin
          do_reset();
          req = 0;
        end else begin
          cycle(req, v, e, r);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
